// File: rtl/uart_tx_if.sv
// Byte-wide ready/valid handshake feeding the buffered UART transmitter.
// The producer drives data_in/data_in_valid; the transmitter answers with data_in_ready.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (output data_in, output data_in_valid, input  data_in_ready);
    modport slave  (input  data_in, input  data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO_DEPTH-entry byte FIFO feeding an 8N1 serial framer.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit (8E1 frame).
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 12_500_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    uart_tx_if.slave                    in_if,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               serial_q, serial_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [7:0]         head;
    logic               push, pop, bit_last;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // Ready depends only on the registered count, so a pop never frees space in the same cycle
    assign in_if.data_in_ready = (count_q < CW'(FIFO_DEPTH));
    assign push       = in_if.data_in_valid && in_if.data_in_ready;
    assign head       = mem[rd_ptr_q];
    assign bit_last   = (bit_cnt_q == CNT_W'(SYMBOL_EDGE_TIME - 1));
    assign serial_out = serial_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_if.data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
        end
    end

    // Shift register holds payload only; a stale value is harmless because IDLE ignores it
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != IDLE) bit_cnt_d = bit_last ? '0 : bit_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (bit_last) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) state_d = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next start bit so frames leave with no idle gap
                if (bit_last) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
        end

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_d;
`endif
            default: serial_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered (SYMBOL_EDGE_TIME=4, FIFO_DEPTH=4).
// A line monitor decodes frames independently; each scenario task checks its own expectations.
module tb_uart_tx_buffered;

    localparam int SET = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * SET;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       serial_out;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx_if bus();

    uart_tx_buffered #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE (12_500_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_if     (bus),
        .serial_out(serial_out),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_stop_ok[$];
    bit         saw_reset = 1'b0;
    logic [7:0] mon_b;
    int         mon_t0;
    bit         mon_ok;

    always @(negedge reset_n) saw_reset = 1'b1;

    // Independent receiver: mid-bit sampling, frames interrupted by reset are dropped
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && serial_out === 1'b0) begin
                mon_t0 = cyc;
                saw_reset = 1'b0;
                mon_b = 8'h00;
                repeat (SET / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (SET) @(negedge clk);
                    mon_b[k] = serial_out;
                end
`ifdef UART_TX_PARITY_EN
                repeat (SET) @(negedge clk);
`endif
                repeat (SET) @(negedge clk);
                mon_ok = (serial_out === 1'b1);
                repeat (SET / 2 - 1) @(negedge clk);
                if (!saw_reset) begin
                    rx_q.push_back(mon_b);
                    rx_t.push_back(mon_t0);
                    rx_stop_ok.push_back(mon_ok);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] d, input bit hold_valid, output int pcyc, output bit ok);
        bus.data_in = d;
        bus.data_in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.data_in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        pcyc = cyc;
        if (!hold_valid) bus.data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!tx_busy) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.data_in = 8'h00;
        bus.data_in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b want 1", serial_out); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (bus.data_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.data_in_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (serial_out !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: serial=%b busy=%b want 1/0", serial_out, tx_busy);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        int pc, bi, base;
        bit ok, e;
        b = 8'h41;
        base = rx_q.size();
        push_byte(b, 1'b0, pc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_push: timed out waiting for ready"); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_push: got %0d want 1", fifo_count); end
        @(posedge clk); #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d want 0", fifo_count); end
        for (int i = 0; i < FRAME_CYC; i++) begin
            bi = i / SET;
            if (bi == 0) e = 1'b0;
            else if (bi <= 8) e = b[bi-1];
            else if (NBITS == 11 && bi == 9) e = ^b;
            else e = 1'b1;
            checks++; if (serial_out !== e || tx_busy !== 1'b1) begin
                errors++; $display("FAIL single_wave[%0d]: serial=%b busy=%b want %b/1", i, serial_out, tx_busy, e);
            end
            @(posedge clk); #1;
        end
        checks++; if (tx_busy !== 1'b0 || serial_out !== 1'b1) begin
            errors++; $display("FAIL single_busy_drop: busy=%b serial=%b want 0/1", tx_busy, serial_out);
        end
        checks++; if (rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== 8'h41) begin
            errors++; $display("FAIL single_rx: got %0d frames, last=%h want 1 frame of 41", rx_q.size() - base,
                               (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        int pc[6];
        int base;
        bit ok;
        logic [7:0] e;
        base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            push_byte(8'h10 + 8'(i), 1'b1, pc[i], ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_push[%0d]: timed out waiting for ready", i); end
            if (i == 4) begin
                checks++; if (fifo_count !== 3'd4 || bus.data_in_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_full: count=%0d ready=%b want 4/0", fifo_count, bus.data_in_ready);
                end
            end
        end
        bus.data_in_valid = 1'b0;
        wait_idle(8 * FRAME_CYC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: tx_busy still high after budget"); end
        checks++; if (rx_q.size() != base + 6) begin
            errors++; $display("FAIL b2b_frames: got %0d frames want 6", rx_q.size() - base);
        end else begin
            checks++; if (rx_t[base] != pc[0] + 1) begin
                errors++; $display("FAIL b2b_latency: start at cycle %0d want %0d", rx_t[base], pc[0] + 1);
            end
            for (int i = 0; i < 6; i++) begin
                e = 8'h10 + 8'(i);
                checks++; if (rx_q[base+i] !== e || !rx_stop_ok[base+i]) begin
                    errors++; $display("FAIL b2b_byte[%0d]: got %h stop_ok=%0d want %h/1", i, rx_q[base+i], rx_stop_ok[base+i], e);
                end
                if (i > 0) begin
                    checks++; if (rx_t[base+i] - rx_t[base+i-1] != FRAME_CYC) begin
                        errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", i, rx_t[base+i] - rx_t[base+i-1], FRAME_CYC);
                    end
                end
            end
        end
    endtask

    task automatic test_full_hold();
        int pc, base, nbad, naa;
        bit ok;
        logic [7:0] e;
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h20 + 8'(i), 1'b1, pc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL hold_fill[%0d]: timed out waiting for ready", i); end
        end
        bus.data_in = 8'hAA;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_count !== 3'd4 || bus.data_in_ready !== 1'b0) nbad++;
            @(posedge clk); #1;
        end
        checks++; if (nbad != 0) begin errors++; $display("FAIL hold_no_write: %0d cycles with count!=4 or ready high, want 0", nbad); end
        push_byte(8'hAA, 1'b0, pc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_push: timed out waiting for ready"); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL hold_count_after_push: got %0d want 4", fifo_count); end
        wait_idle(8 * FRAME_CYC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_drain: tx_busy still high after budget"); end
        naa = 0;
        for (int i = base; i < rx_q.size(); i++) if (rx_q[i] === 8'hAA) naa++;
        checks++; if (rx_q.size() != base + 6 || naa != 1) begin
            errors++; $display("FAIL hold_frames: got %0d frames with %0d of AA want 6 with 1", rx_q.size() - base, naa);
        end else begin
            for (int i = 0; i < 6; i++) begin
                e = (i < 5) ? 8'h20 + 8'(i) : 8'hAA;
                checks++; if (rx_q[base+i] !== e) begin
                    errors++; $display("FAIL hold_byte[%0d]: got %h want %h", i, rx_q[base+i], e);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int pc, base, nlow;
        bit ok;
        push_byte(8'h33, 1'b0, pc, ok);
        push_byte(8'h44, 1'b0, pc, ok);
        push_byte(8'h55, 1'b0, pc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_push: timed out waiting for ready"); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (fifo_count !== 3'd2 || serial_out !== 1'b0 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL midrst_before: count=%0d serial=%b busy=%b want 2/0/1", fifo_count, serial_out, tx_busy);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (serial_out !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || bus.data_in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_during: serial=%b count=%0d busy=%b ready=%b want 1/0/0/1",
                               serial_out, fifo_count, tx_busy, bus.data_in_ready);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        base = rx_q.size();
        nlow = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (serial_out !== 1'b1 || tx_busy !== 1'b0) nlow++;
        end
        checks++; if (nlow != 0 || rx_q.size() != base) begin
            errors++; $display("FAIL midrst_quiet: %0d active cycles, %0d frames want 0/0", nlow, rx_q.size() - base);
        end
        push_byte(8'h5A, 1'b0, pc, ok);
        wait_idle(2 * FRAME_CYC, ok);
        checks++; if (!ok || rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== 8'h5A) begin
            errors++; $display("FAIL midrst_recover: got %0d frames last=%h want 1 frame of 5a", rx_q.size() - base,
                               (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'hxx);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       par  [2];
        int pc;
        bit ok;
        vals[0] = 8'h07; par[0] = 1'b1;
        vals[1] = 8'h03; par[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            push_byte(vals[v], 1'b0, pc, ok);
            @(posedge clk); #1;
            repeat (34) @(posedge clk);
            #1;
            checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL parity_d7[%0d]: got %b want 0", v, serial_out); end
            repeat (4) @(posedge clk);
            #1;
            checks++; if (serial_out !== par[v]) begin errors++; $display("FAIL parity_bit[%0d]: got %b want %b", v, serial_out, par[v]); end
            repeat (4) @(posedge clk);
            #1;
            checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL parity_stop[%0d]: got %b want 1", v, serial_out); end
            @(posedge clk); #1;
            checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL parity_busy43[%0d]: got %b want 1", v, tx_busy); end
            @(posedge clk); #1;
            checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL parity_len[%0d]: busy=%b at 44 cycles want 0", v, tx_busy); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_hold();
        test_mid_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
